// File: rtl/jtframe_rom_pkg.sv
// ----------------------------------------------------------------------------
// jtframe_rom_pkg
//
// Shared definitions for the narrow ROM arbiter:
//   - rom_state_t and the three controller state constants
//   - sel_width(): width of a slot index (never less than one bit)
//
// Build option JTFRAME_ROM_RR_EN (used by jtframe_rom_narb) selects
// round-robin arbitration. Without it, fixed priority is used.
// ----------------------------------------------------------------------------
package jtframe_rom_pkg;

    typedef logic [1:0] rom_state_t;

    localparam rom_state_t ST_IDLE      = 2'd0;
    localparam rom_state_t ST_WAIT_ACK  = 2'd1;
    localparam rom_state_t ST_WAIT_DATA = 2'd2;

    // A single slot still needs a one-bit index so that vectors stay legal
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rom_slotcache.sv
// ----------------------------------------------------------------------------
// jtframe_rom_slotcache
//
// One-entry read cache for a single requesting slot.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : clears the valid bit (has priority over fill)
//   fill       : writes fill_addr/fill_data into the entry and marks it valid
//   fill_addr  : tag to store (the address that was actually fetched)
//   fill_data  : word returned by the SDRAM
//   cs, addr   : the slot's current request and word address
//   ok         : cached word is valid for the current request
//   dout       : cached word
// ----------------------------------------------------------------------------
module jtframe_rom_slotcache
    import jtframe_rom_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;

    // A flush in the same cycle as a fill leaves the entry invalid, so a word
    // fetched before the flush can never be served afterwards.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_addr;
            data_d  = fill_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign ok   = cs & valid_q & (tag_q == addr);
    assign dout = data_q;

endmodule

// File: rtl/jtframe_rom_narb.sv
// ----------------------------------------------------------------------------
// jtframe_rom_narb
//
// Arbitrates SLOTS read-only clients onto one SDRAM read port. Each slot has
// a one-entry cache; a slot whose request misses its cache competes for the
// SDRAM, and the returned word is stored under the address that was fetched.
//
// Parameters: SLOTS (1..9), AW (word address width), DW (read data width)
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   downloading   : ROM load in progress; flushes caches, blocks requests
//   loop_rst      : synchronous cache flush
//   slot_cs       : per-slot request
//   slot_addr     : packed per-slot word address, slot 0 in the LSBs
//   slot_ok       : per-slot hit for the current address
//   slot_dout     : packed per-slot cached word
//   sdram_req     : read request, held until sdram_ack
//   sdram_addr    : address of the current request, stable until data_rdy
//   sdram_ack     : SDRAM accepted the request
//   data_rdy      : data_read is valid
//   data_read     : SDRAM read data
//   refresh_en    : controller idle and no slot waiting; refresh allowed
//
// Build option: define JTFRAME_ROM_RR_EN for round-robin arbitration (search
// starts after the last winner). Otherwise the lowest pending slot wins.
// ----------------------------------------------------------------------------
module jtframe_rom_narb
    import jtframe_rom_pkg::*;
#(
    parameter int SLOTS = 5,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int WW = sel_width(SLOTS);

    rom_state_t    state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [WW-1:0] winner_q, winner_d;
    logic          discard_q, discard_d;

    logic             flush;
    logic [SLOTS-1:0] pending;
    logic [SLOTS-1:0] fill_vec;
    logic [AW-1:0]    addr_arr [SLOTS];
    logic             found;
    logic             grant;
    logic [WW-1:0]    grant_idx;

`ifdef JTFRAME_ROM_RR_EN
    // Slot where the next search begins (one past the last winner)
    logic [WW-1:0] ptr_q, ptr_d;
`endif

    assign flush   = loop_rst | downloading;
    assign pending = slot_cs & ~slot_ok;

    generate
        for (genvar i = 0; i < SLOTS; i++) begin : g_slot
            assign addr_arr[i] = slot_addr[i*AW +: AW];

            jtframe_rom_slotcache #(
                .AW (AW),
                .DW (DW)
            ) u_cache (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .fill      (fill_vec[i]),
                .fill_addr (addr_q),
                .fill_data (data_read),
                .cs        (slot_cs[i]),
                .addr      (addr_arr[i]),
                .ok        (slot_ok[i]),
                .dout      (slot_dout[i*DW +: DW])
            );
        end
    endgenerate

    // Scan all slots starting at 'start', wrapping once; the first pending
    // slot found wins. With fixed priority the scan always starts at slot 0.
    always_comb begin
        int            start;
        int            idx;
        logic [WW-1:0] sel;
        found     = 1'b0;
        grant_idx = '0;
        start     = 0;
        idx       = 0;
        sel       = '0;
`ifdef JTFRAME_ROM_RR_EN
        start     = int'(ptr_q);
`endif
        for (int k = 0; k < SLOTS; k++) begin
            idx = start + k;
            if (idx >= SLOTS) begin
                idx = idx - SLOTS;
            end
            sel = idx[WW-1:0];
            if (!found && pending[sel]) begin
                found     = 1'b1;
                grant_idx = sel;
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && found && !downloading;

`ifdef JTFRAME_ROM_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (grant_idx == WW'(SLOTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Request controller. discard marks a transaction that a flush overtook:
    // it still runs to completion on the SDRAM side but its data is dropped.
    // A grant taken in the same cycle as loop_rst is discarded as well.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        winner_d  = winner_q;
        discard_d = discard_q;
        fill_vec  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    winner_d  = grant_idx;
                    addr_d    = addr_arr[grant_idx];
                    req_d     = 1'b1;
                    discard_d = loop_rst;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (data_rdy) begin
                    if (!discard_q && !flush) begin
                        fill_vec[winner_q] = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && flush) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            winner_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            winner_q  <= winner_d;
            discard_q <= discard_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = (state_q == ST_IDLE) && !(|pending);

endmodule

// File: tb/tb_jtframe_rom_narb.sv
// ----------------------------------------------------------------------------
// tb_jtframe_rom_narb
//
// Bench for jtframe_rom_narb. A transaction-level model of the slot caches
// and the single outstanding SDRAM read is stepped on every rising edge and
// compared with the DUT shortly after. Directed scenarios add literal checks.
// The same JTFRAME_ROM_RR_EN option selects the arbitration the model uses.
// ----------------------------------------------------------------------------
module tb_jtframe_rom_narb;

    localparam int SLOTS = 5;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                downloading = 1'b0;
    logic                loop_rst = 1'b0;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                refresh_en;

    int total = 0;
    int bad   = 0;

    // SDRAM responder settings
    bit auto_resp  = 1'b1;
    int ack_delay  = 1;
    int data_delay = 1;

    // Model state: cache contents and the one outstanding read
    bit            m_valid [SLOTS];
    logic [AW-1:0] m_tag   [SLOTS];
    logic [DW-1:0] m_data  [SLOTS];
    bit            m_busy;
    bit            m_req;
    bit            m_cancel;
    logic [AW-1:0] m_addr;
    int            m_slot;
    int            m_next;
    int            grant_q [$];

    jtframe_rom_narb #(
        .SLOTS (SLOTS),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    // ROM contents seen by the responder
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == 22'h001234) return 32'hDEADBEEF;
        return {10'h15A, a} ^ 32'h00A55A00;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int slot, input logic cs, input logic [AW-1:0] a);
        slot_cs[slot]            = cs;
        slot_addr[slot*AW +: AW] = a;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitOk(input int slot, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!slot_ok[slot] && n < budget);
        checkOutput(name, slot_ok[slot], 1'b1);
    endtask

    task automatic waitReq(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sdram_req && n < budget);
        checkOutput(name, sdram_req, 1'b1);
    endtask

    task automatic waitAllOk(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (slot_ok != {SLOTS{1'b1}} && n < budget);
        checkOutput(name, slot_ok, {SLOTS{1'b1}});
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_ok(input int i);
        return slot_cs[i] && m_valid[i] && (m_tag[i] == slot_addr[i*AW +: AW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        m_busy   = 1'b0;
        m_req    = 1'b0;
        m_cancel = 1'b0;
        m_addr   = '0;
        m_slot   = 0;
        m_next   = 0;
    endtask

    // Advance one clock using the inputs present at the rising edge
    task automatic model_step();
        bit pend [SLOTS];
        bit any_pend;
        bit flush_now;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        any_pend = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            pend[i]  = slot_cs[i] && !model_ok(i);
            any_pend = any_pend || pend[i];
        end
        flush_now = loop_rst || downloading;
        if (!m_busy) begin
            if (any_pend && !downloading) begin
                w = -1;
                for (int k = 0; k < SLOTS; k++) begin
`ifdef JTFRAME_ROM_RR_EN
                    if (w < 0 && pend[(m_next + k) % SLOTS]) w = (m_next + k) % SLOTS;
`else
                    if (w < 0 && pend[k]) w = k;
`endif
                end
                m_next   = (w + 1) % SLOTS;
                m_busy   = 1'b1;
                m_req    = 1'b1;
                m_slot   = w;
                m_addr   = slot_addr[w*AW +: AW];
                m_cancel = loop_rst;
                grant_q.push_back(w);
            end
        end else if (m_req) begin
            if (sdram_ack) m_req = 1'b0;
            if (flush_now) m_cancel = 1'b1;
        end else begin
            if (data_rdy) begin
                if (!m_cancel && !flush_now) begin
                    m_valid[m_slot] = 1'b1;
                    m_tag[m_slot]   = m_addr;
                    m_data[m_slot]  = data_read;
                end
                m_busy = 1'b0;
            end else if (flush_now) begin
                m_cancel = 1'b1;
            end
        end
        if (flush_now) begin
            for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [SLOTS-1:0] eok;
        for (int i = 0; i < SLOTS; i++) eok[i] = model_ok(i);
        checkOutput("slot_ok", slot_ok, eok);
        for (int i = 0; i < SLOTS; i++) begin
            checkOutput($sformatf("slot_dout%0d", i), slot_dout[i*DW +: DW], m_data[i]);
        end
        checkOutput("sdram_req", sdram_req, m_req);
        checkOutput("sdram_addr", sdram_addr, m_addr);
        checkOutput("refresh_en", refresh_en, !m_busy && ((slot_cs & ~eok) == '0));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    end

    // ---------------- SDRAM responder ----------------
    initial begin
        int phase;
        int cnt;
        logic [AW-1:0] lat;
        phase = 0;
        cnt   = 0;
        lat   = '0;
        forever begin
            @(negedge clk);
            if (auto_resp) begin
                sdram_ack = 1'b0;
                data_rdy  = 1'b0;
                if (rst) begin
                    phase = 0;
                    cnt   = 0;
                end else if (phase == 0) begin
                    if (sdram_req) begin
                        cnt++;
                        if (cnt >= ack_delay) begin
                            sdram_ack = 1'b1;
                            lat       = sdram_addr;
                            phase     = 1;
                            cnt       = 0;
                        end
                    end
                end else begin
                    cnt++;
                    if (cnt >= data_delay) begin
                        data_rdy  = 1'b1;
                        data_read = mem(lat);
                        phase     = 0;
                        cnt       = 0;
                    end
                end
            end else begin
                phase = 0;
                cnt   = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int  cnt;
        bit  stable;
        bit  saw200;
        bit  early;
        logic [AW-1:0] first_addr;

        // Reset state
        waitCycles(2);
        checkOutput("rst_ok", slot_ok, '0);
        checkOutput("rst_req", sdram_req, 1'b0);
        checkOutput("rst_addr", sdram_addr, '0);
        checkOutput("rst_refresh", refresh_en, 1'b1);
        rst = 1'b0;

        // Hit after a fill of slot 2
        ack_delay  = 2;
        data_delay = 1;
        applyStimulus(2, 1'b1, 22'h001234);
        waitOk(2, 40, "hit_wait");
        checkOutput("hit_ok", slot_ok[2], 1'b1);
        checkOutput("hit_dout", slot_dout[2*DW +: DW], 32'hDEADBEEF);
        checkOutput("hit_noreq", sdram_req, 1'b0);
        waitCycles(3);
        checkOutput("hit_noreq_later", sdram_req, 1'b0);

        // Acknowledge held off for 7 cycles
        ack_delay = 7;
        applyStimulus(4, 1'b1, 22'h003000);
        waitReq(20, "ack7_req");
        first_addr = sdram_addr;
        cnt    = 0;
        stable = 1'b1;
        for (int n = 0; n < 30 && sdram_req; n++) begin
            cnt++;
            if (sdram_addr !== first_addr) stable = 1'b0;
            @(negedge clk);
        end
        checkOutput("ack7_len", cnt, 7);
        checkOutput("ack7_stable", stable, 1'b1);
        checkOutput("ack7_addr", first_addr, 22'h003000);
        waitOk(4, 40, "ack7_fill");

        // Three slots missing at once
        ack_delay = 1;
        grant_q.delete();
        applyStimulus(2, 1'b0, 22'h001234);
        applyStimulus(4, 1'b0, 22'h003000);
        applyStimulus(0, 1'b1, 22'h100000);
        applyStimulus(1, 1'b1, 22'h110000);
        applyStimulus(3, 1'b1, 22'h130000);
        waitOk(3, 100, "cont_wait");
        checkOutput("cont_count", grant_q.size(), 3);
        if (grant_q.size() == 3) begin
            checkOutput("cont_g0", grant_q[0], 0);
            checkOutput("cont_g1", grant_q[1], 1);
            checkOutput("cont_g2", grant_q[2], 3);
        end
        checkOutput("cont_ok", slot_ok, 5'b01011);

        // Dropping slot_cs kept slot 2's entry
        applyStimulus(2, 1'b1, 22'h001234);
        #1;
        checkOutput("cs_keep_ok", slot_ok[2], 1'b1);
        checkOutput("cs_keep_dout", slot_dout[2*DW +: DW], 32'hDEADBEEF);

        // Slot 0 keeps missing while slot 1 waits
        grant_q.delete();
        applyStimulus(1, 1'b1, 22'h111111);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 1'b1, 22'h100000 + k);
            waitOk(0, 100, "starve_wait0");
        end
        applyStimulus(0, 1'b0, 22'h100003);
        waitOk(1, 100, "starve_wait1");
        checkOutput("starve_count", grant_q.size(), 4);
        if (grant_q.size() == 4) begin
`ifdef JTFRAME_ROM_RR_EN
            checkOutput("rr_g0", grant_q[0], 0);
            checkOutput("rr_g1", grant_q[1], 1);
            checkOutput("rr_g2", grant_q[2], 0);
            checkOutput("rr_g3", grant_q[3], 0);
`else
            checkOutput("fp_g0", grant_q[0], 0);
            checkOutput("fp_g1", grant_q[1], 0);
            checkOutput("fp_g2", grant_q[2], 0);
            checkOutput("fp_g3", grant_q[3], 1);
`endif
        end

        // Address changes while its read is outstanding
        data_delay = 4;
        applyStimulus(1, 1'b1, 22'h000100);
        waitReq(20, "chg_req");
        checkOutput("chg_addr1", sdram_addr, 22'h000100);
        waitCycles(1);
        applyStimulus(1, 1'b1, 22'h000200);
        saw200 = 1'b0;
        early  = 1'b0;
        for (int n = 0; n < 60 && !slot_ok[1]; n++) begin
            @(negedge clk);
            if (sdram_req && sdram_addr == 22'h000200) saw200 = 1'b1;
            if (slot_ok[1] && !saw200) early = 1'b1;
        end
        checkOutput("chg_saw200", saw200, 1'b1);
        checkOutput("chg_early", early, 1'b0);
        checkOutput("chg_ok", slot_ok[1], 1'b1);
        checkOutput("chg_dout", slot_dout[1*DW +: DW], mem(22'h000200));

        // Flush with every entry valid, then a download window
        data_delay = 1;
        applyStimulus(0, 1'b1, 22'h100003);
        applyStimulus(4, 1'b1, 22'h003000);
        #1;
        checkOutput("flush_all_ok", slot_ok, 5'b11111);
        waitCycles(1);
        loop_rst = 1'b1;
        waitCycles(1);
        loop_rst = 1'b0;
        downloading = 1'b1;
        checkOutput("flush_ok", slot_ok, '0);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (sdram_req) cnt++;
        end
        checkOutput("dl_noreq", cnt, 0);
        downloading = 1'b0;
        waitAllOk(200, "refill_all");

        // Flush while a fill is in flight
        data_delay = 3;
        applyStimulus(4, 1'b1, 22'h003333);
        waitReq(20, "midflush_req");
        waitCycles(2);
        loop_rst = 1'b1;
        waitCycles(1);
        loop_rst = 1'b0;
        checkOutput("midflush_ok", slot_ok, '0);
        waitAllOk(300, "midflush_refill");
        checkOutput("midflush_dout", slot_dout[4*DW +: DW], mem(22'h003333));

        // Reset while waiting for data, then a stray data_rdy
        data_delay = 1;
        for (int i = 0; i < SLOTS; i++) slot_cs[i] = 1'b0;
        waitCycles(2);
        auto_resp = 1'b0;
        waitCycles(1);
        applyStimulus(3, 1'b1, 22'h135555);
        waitReq(20, "rstmid_req");
        sdram_ack = 1'b1;
        waitCycles(1);
        sdram_ack = 1'b0;
        waitCycles(1);
        applyStimulus(3, 1'b0, 22'h135555);
        rst = 1'b1;
        waitCycles(1);
        applyStimulus(2, 1'b1, 22'h001234);
        #1;
        checkOutput("rstmid_ok", slot_ok, '0);
        checkOutput("rstmid_req_low", sdram_req, 1'b0);
        applyStimulus(2, 1'b0, 22'h001234);
        waitCycles(1);
        rst = 1'b0;
        data_rdy  = 1'b1;
        data_read = 32'h12345678;
        waitCycles(1);
        data_rdy = 1'b0;
        checkOutput("late_rdy_noreq", sdram_req, 1'b0);
        applyStimulus(3, 1'b1, 22'h135555);
        #1;
        checkOutput("late_rdy_ok", slot_ok[3], 1'b0);
        auto_resp = 1'b1;
        waitOk(3, 40, "rstmid_refill");
        checkOutput("rstmid_dout", slot_dout[3*DW +: DW], mem(22'h135555));

        waitCycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtframe_rom_narb.md
JTFRAME_ROM_NARB -- requirements
Module: jtframe_rom_narb

Interface
REQ-001 parameter SLOTS, default 5, number of requesting slots (1..9).
REQ-002 parameter AW, default 22, SDRAM word-address width.
REQ-003 parameter DW, default 32, SDRAM read-data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 downloading  input  1  ROM load in progress; blocks all requests.
REQ-007 loop_rst  input  1  synchronous flush; invalidates every slot cache.
REQ-008 slot_cs  input  SLOTS  per-slot read request.
REQ-009 slot_addr  input  SLOTS*AW  packed per-slot word address, slot 0 in LSBs, offsets already applied.
REQ-010 slot_ok  output  SLOTS  per-slot data valid for the current slot_addr.
REQ-011 slot_dout  output  SLOTS*DW  packed per-slot cached word.
REQ-012 sdram_req  output  1  SDRAM read request.
REQ-013 sdram_addr  output  AW  address of the current request.
REQ-014 sdram_ack  input  1  SDRAM accepted request.
REQ-015 data_rdy  input  1  data_read valid.
REQ-016 data_read  input  DW  SDRAM read data.
REQ-017 refresh_en  output  1  SDRAM may refresh.

Function
REQ-018 Each slot SHALL hold a one-entry cache: valid bit, AW-bit tag, DW-bit data.
REQ-019 slot_ok[i] SHALL equal slot_cs[i] AND valid[i] AND (tag[i]==slot_addr[i]), combinational from registered cache.
REQ-020 A slot SHALL be pending when slot_cs high and slot_ok low.
REQ-021 FSM states: IDLE, WAIT_ACK, WAIT_DATA.
REQ-022 IDLE: with any slot pending and downloading low, SHALL latch winner index and its address, assert sdram_req next cycle, go WAIT_ACK.
REQ-023 WAIT_ACK: sdram_req held high until sdram_ack; on ack, sdram_req low same edge, go WAIT_DATA.
REQ-024 WAIT_DATA: on data_rdy, SHALL write data_read and latched address into winner's cache, set valid, return IDLE; minimum hit latency after data_rdy is one cycle.
REQ-025 Slot whose address changes during its outstanding request SHALL still receive the fill under the latched address; slot_ok stays low and a new request follows.
REQ-026 sdram_addr SHALL remain stable from request until data_rdy.
REQ-027 refresh_en SHALL be high only in IDLE with no slot pending.
REQ-028 downloading high SHALL clear all valid bits each cycle and inhibit new requests; an in-flight transaction completes but is not cached.
REQ-029 loop_rst SHALL clear all valid bits; in-flight transaction completes without caching.
REQ-030 slot_cs low SHALL not invalidate cache.

Reset
REQ-031 rst SHALL force IDLE, sdram_req=0, sdram_addr=0, all valid=0, tags=0, data=0, winner=0, round-robin pointer=0; slot_ok=0, refresh_en=1 while no slot pending.
REQ-032 rst mid-transaction SHALL abandon it; late data_rdy after reset SHALL be ignored in IDLE.

Configuration
REQ-033 Macro JTFRAME_ROM_RR_EN defined: round-robin arbitration; search starts at slot after last winner, pointer updates on each grant.
REQ-034 Macro undefined: fixed priority, lowest slot index wins.

Structure
REQ-035 Package jtframe_rom_pkg SHALL hold the FSM state type and state constants.
REQ-036 Sub-module jtframe_rom_slotcache SHALL implement one slot's valid/tag/data and ok compare; instantiated SLOTS times by generate.

Verification
REQ-037 Hit: slot 2 addr 0x001234 filled with 0xDEADBEEF; next cycle slot_ok[2]=1, dout=0xDEADBEEF, no sdram_req.
REQ-038 Contention, RR_EN defined: slots 0,1,3 pending simultaneously -> grants 0,1,3 in order; undefined -> 0,1,3 also, but with slot 0 re-missing each time, slot 1 starves while 0 pending.
REQ-039 Ack delay: sdram_ack after 7 cycles -> sdram_req high exactly 7 cycles, sdram_addr constant.
REQ-040 Address change: slot 1 switches 0x100 -> 0x200 before data_rdy -> ok stays 0, second request to 0x200 issued, then ok=1.
REQ-041 Flush: loop_rst pulse with all caches valid -> all slot_ok=0 next cycle; downloading high -> sdram_req never asserts.
REQ-042 Reset in WAIT_DATA -> IDLE, sdram_req=0, all slot_ok=0; following data_rdy produces no cache write.
